// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result inputs, buffer-ready feedback and the two registered CDB broadcast buses.
// Per-FU fields are packed flat with FU i in slice i; buses are {valid, rob, rd, result}.
interface cdb_arbiter_if #(
    parameter int PREG_WIDTH = 6,
    parameter int ROB_WIDTH  = 6
);
    localparam int NUM_FU = 3;
    localparam int BUS_W  = 1 + ROB_WIDTH + PREG_WIDTH + 32;

    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU*PREG_WIDTH-1:0] fu_rd;
    logic [NUM_FU*32-1:0]         fu_result;
    logic [NUM_FU*ROB_WIDTH-1:0]  fu_rob;
    logic [NUM_FU-1:0]            fu_ready;
    logic [BUS_W-1:0]             bus0;
    logic [BUS_W-1:0]             bus1;
    logic                         overflow;

    modport master (
        output fu_valid, fu_rd, fu_result, fu_rob,
        input  fu_ready, bus0, bus1, overflow
    );

    modport slave (
        input  fu_valid, fu_rd, fu_result, fu_rob,
        output fu_ready, bus0, bus1, overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU 2-entry result FIFOs, round-robin arbitrated onto two registered CDB buses.
// Defining CDB_BYPASS_EN lets a result arriving at an empty FIFO win a bus in the same cycle.
module cdb_arbiter #(
    parameter int PREG_WIDTH = 6,
    parameter int ROB_WIDTH  = 6
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave cdb
);
    localparam int NUM_FU     = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int ENT_W      = ROB_WIDTH + PREG_WIDTH + 32;
    localparam int BUS_W      = 1 + ENT_W;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [1:0] r;
        case (v)
            3'd0:    r = 2'd0;
            3'd1:    r = 2'd1;
            3'd2:    r = 2'd2;
            3'd3:    r = 2'd0;
            3'd4:    r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [ENT_W-1:0]  mem_r [NUM_FU][FIFO_DEPTH];
    logic [1:0]        count_r [NUM_FU];
    logic [NUM_FU-1:0] rd_ptr_r;
    logic [NUM_FU-1:0] wr_ptr_r;
    logic [NUM_FU-1:0] ready_r;
    logic [2:0]        rr_ptr_r;
    logic              overflow_r;
    logic [BUS_W-1:0]  bus0_r;
    logic [BUS_W-1:0]  bus1_r;

    logic [ENT_W-1:0]  in_ent_s  [NUM_FU];
    logic [ENT_W-1:0]  src_ent_s [NUM_FU];
    logic [1:0]        count_next_s [NUM_FU];
    logic [NUM_FU-1:0] push_s;
    logic [NUM_FU-1:0] drop_s;
    logic [NUM_FU-1:0] bypass_s;
    logic [NUM_FU-1:0] elig_s;
    logic [NUM_FU-1:0] grant_s;
    logic [NUM_FU-1:0] write_s;
    logic [NUM_FU-1:0] fifo_pop_s;
    logic [NUM_FU-1:0] ready_next_s;
    logic [1:0]        scan_idx_s;
    logic [1:0]        g0_idx_s;
    logic [1:0]        g1_idx_s;
    logic              g0_vld_s;
    logic              g1_vld_s;
    logic [2:0]        rr_next_s;

    // Unpack FU inputs, classify pushes/drops and decide bus eligibility per FU.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_ent_s[i] = {cdb.fu_rob[i*ROB_WIDTH +: ROB_WIDTH],
                           cdb.fu_rd[i*PREG_WIDTH +: PREG_WIDTH],
                           cdb.fu_result[i*32 +: 32]};
            push_s[i] = cdb.fu_valid[i] & ready_r[i];
            drop_s[i] = cdb.fu_valid[i] & ~ready_r[i];
`ifdef CDB_BYPASS_EN
            bypass_s[i] = push_s[i] & (count_r[i] == 2'd0);
`else
            bypass_s[i] = 1'b0;
`endif
            elig_s[i] = (count_r[i] != 2'd0) | bypass_s[i];
            // An empty FIFO can only be granted through the bypass, so its source is the live input.
            src_ent_s[i] = (count_r[i] == 2'd0) ? in_ent_s[i] : mem_r[i][rd_ptr_r[i]];
        end
    end

    // Round-robin scan: first eligible FU takes bus0, second takes bus1.
    always_comb begin
        g0_vld_s   = 1'b0;
        g1_vld_s   = 1'b0;
        g0_idx_s   = 2'd0;
        g1_idx_s   = 2'd0;
        scan_idx_s = 2'd0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx_s = wrap3(rr_ptr_r + 3'(k));
            if (elig_s[scan_idx_s] && !g0_vld_s) begin
                g0_vld_s = 1'b1;
                g0_idx_s = scan_idx_s;
            end else if (elig_s[scan_idx_s] && !g1_vld_s) begin
                g1_vld_s = 1'b1;
                g1_idx_s = scan_idx_s;
            end else begin
                g1_vld_s = g1_vld_s;
            end
        end
        if (g1_vld_s) begin
            rr_next_s = {1'b0, wrap3({1'b0, g1_idx_s} + 3'd1)};
        end else if (g0_vld_s) begin
            rr_next_s = {1'b0, wrap3({1'b0, g0_idx_s} + 3'd1)};
        end else begin
            rr_next_s = rr_ptr_r;
        end
    end

    // Per-FU FIFO update: granted bypass results skip the FIFO entirely.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            grant_s[i]         = (g0_vld_s && (g0_idx_s == 2'(i))) ||
                                 (g1_vld_s && (g1_idx_s == 2'(i)));
            write_s[i]         = push_s[i] & ~(bypass_s[i] & grant_s[i]);
            fifo_pop_s[i]      = grant_s[i] & (count_r[i] != 2'd0);
            count_next_s[i]    = count_r[i] + {1'b0, write_s[i]} - {1'b0, fifo_pop_s[i]};
            ready_next_s[i]    = (count_next_s[i] < 2'd2);
        end
    end

    // FIFO storage, pointers and counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count_r[i]  <= 2'd0;
                mem_r[i][0] <= '0;
                mem_r[i][1] <= '0;
            end
            rd_ptr_r <= 3'b000;
            wr_ptr_r <= 3'b000;
            ready_r  <= 3'b111;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (write_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= in_ent_s[i];
                    wr_ptr_r[i]           <= ~wr_ptr_r[i];
                end
                if (fifo_pop_s[i]) begin
                    rd_ptr_r[i] <= ~rd_ptr_r[i];
                end
                count_r[i] <= count_next_s[i];
            end
            ready_r <= ready_next_s;
        end
    end

    // Bus registers, round-robin pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus0_r     <= '0;
            bus1_r     <= '0;
            rr_ptr_r   <= 3'd0;
            overflow_r <= 1'b0;
        end else begin
            if (g0_vld_s) begin
                bus0_r <= {1'b1, src_ent_s[g0_idx_s]};
            end else begin
                bus0_r[BUS_W-1] <= 1'b0;
            end
            if (g1_vld_s) begin
                bus1_r <= {1'b1, src_ent_s[g1_idx_s]};
            end else begin
                bus1_r[BUS_W-1] <= 1'b0;
            end
            rr_ptr_r <= rr_next_s;
            if (|drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign cdb.fu_ready = ready_r;
    assign cdb.bus0     = bus0_r;
    assign cdb.bus1     = bus1_r;
    assign cdb.overflow = overflow_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus randomized stimulus checked against a queue-level model of the arbiter.
module tb_cdb_arbiter;
    localparam int PW = 6;
    localparam int RW = 6;
    localparam int EW = RW + PW + 32;
    localparam int BW = EW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.PREG_WIDTH(PW), .ROB_WIDTH(RW)) cdb();
    cdb_arbiter #(.PREG_WIDTH(PW), .ROB_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cdb   (cdb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: per-FU ordered buffer (slot 0 = oldest), round-robin start, bus images.
    logic [EW-1:0] m_q [3][2];
    int            m_cnt [3];
    int            m_rr;
    bit            m_ovf;
    logic [BW-1:0] m_bus0;
    logic [BW-1:0] m_bus1;

    logic [2:0]    in_v;
    logic [EW-1:0] in_e [3];
    logic [RW-1:0] rob_seq = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_ent(input logic [RW-1:0] rob, input logic [PW-1:0] rd,
                                             input logic [31:0] res);
        return {rob, rd, res};
    endfunction

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (m_cnt[i] < 2);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_rr   = 0;
        m_ovf  = 1'b0;
        m_bus0 = '0;
        m_bus1 = '0;
    endtask

    task automatic model_step();
        logic [2:0]    rdy;
        int            granted [$];
        bit            byp_used [3];
        logic [EW-1:0] data;
        bit            elig;
        int            fu;
        rdy = model_ready();
        for (int i = 0; i < 3; i++) byp_used[i] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fu   = (m_rr + k) % 3;
            elig = (m_cnt[fu] > 0);
`ifdef CDB_BYPASS_EN
            if (m_cnt[fu] == 0 && in_v[fu]) elig = 1'b1;
`endif
            if (elig && granted.size() < 2) granted.push_back(fu);
        end
        for (int j = 0; j < granted.size(); j++) begin
            fu = granted[j];
            if (m_cnt[fu] > 0) begin
                data        = m_q[fu][0];
                m_q[fu][0]  = m_q[fu][1];
                m_cnt[fu]--;
            end else begin
                data         = in_e[fu];
                byp_used[fu] = 1'b1;
            end
            if (j == 0) m_bus0 = {1'b1, data};
            else        m_bus1 = {1'b1, data};
        end
        if (granted.size() < 1) m_bus0[BW-1] = 1'b0;
        if (granted.size() < 2) m_bus1[BW-1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (in_v[i]) begin
                if (!rdy[i]) begin
                    m_ovf = 1'b1;
                end else if (!byp_used[i]) begin
                    m_q[i][m_cnt[i]] = in_e[i];
                    m_cnt[i]++;
                end
            end
        end
        if (granted.size() > 0) m_rr = (granted[granted.size()-1] + 1) % 3;
    endtask

    task automatic drive_inputs();
        cdb.fu_valid = in_v;
        for (int i = 0; i < 3; i++) begin
            cdb.fu_rob[i*RW +: RW]    = in_e[i][EW-1 -: RW];
            cdb.fu_rd[i*PW +: PW]     = in_e[i][32 +: PW];
            cdb.fu_result[i*32 +: 32] = in_e[i][31:0];
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_bus0"}, 64'(cdb.bus0), 64'(m_bus0));
        check_val({tag, "_bus1"}, 64'(cdb.bus1), 64'(m_bus1));
        check_val({tag, "_ready"}, 64'(cdb.fu_ready), 64'(model_ready()));
        check_val({tag, "_ovf"}, 64'(cdb.overflow), 64'(m_ovf));
        if (cdb.bus0[BW-1] && cdb.bus1[BW-1])
            check_val({tag, "_rob_distinct"}, 64'(cdb.bus0[EW-1 -: RW] == cdb.bus1[EW-1 -: RW]), 64'd0);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        drive_inputs();
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_v = 3'b000;
        for (int i = 0; i < 3; i++) in_e[i] = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        drive_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_bus0_valid", 64'(cdb.bus0[BW-1]), 64'd0);
        check_val("reset_bus1_valid", 64'(cdb.bus1[BW-1]), 64'd0);
        check_val("reset_ready", 64'(cdb.fu_ready), 64'h7);
        check_val("reset_ovf", 64'(cdb.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");
        step("idle");

        // Two FUs at once from rr_ptr=0: FU0 on bus0, FU2 on bus1.
        in_v = 3'b101;
        in_e[0] = mk_ent(6'd5, 6'd10, 32'h11);
        in_e[2] = mk_ent(6'd7, 6'd12, 32'h22);
        step("pair_push");
        idle_inputs();
`ifdef CDB_BYPASS_EN
        check_val("pair_bus0_lit", 64'(cdb.bus0), 64'({1'b1, 6'd5, 6'd10, 32'h11}));
        check_val("pair_bus1_lit", 64'(cdb.bus1), 64'({1'b1, 6'd7, 6'd12, 32'h22}));
        step("pair_next");
`else
        step("pair_next");
        check_val("pair_bus0_lit", 64'(cdb.bus0), 64'({1'b1, 6'd5, 6'd10, 32'h11}));
        check_val("pair_bus1_lit", 64'(cdb.bus1), 64'({1'b1, 6'd7, 6'd12, 32'h22}));
`endif
        repeat (3) step("drain");

        // Single FU2 push into an empty arbiter: latency depends on the bypass build.
        in_v = 3'b100;
        in_e[2] = mk_ent(6'd33, 6'd3, 32'hCAFE0002);
        step("lat_push");
        idle_inputs();
`ifdef CDB_BYPASS_EN
        check_val("lat_same_edge", 64'(cdb.bus0), 64'({1'b1, 6'd33, 6'd3, 32'hCAFE0002}));
        step("lat_next");
        check_val("lat_next_valid", 64'(cdb.bus0[BW-1]), 64'd0);
`else
        check_val("lat_not_yet", 64'(cdb.bus0[BW-1]), 64'd0);
        step("lat_next");
        check_val("lat_one_later", 64'(cdb.bus0), 64'({1'b1, 6'd33, 6'd3, 32'hCAFE0002}));
`endif
        repeat (3) step("drain");

        // Saturate: all FUs push every cycle regardless of ready, forcing a drop.
        for (int c = 0; c < 6; c++) begin
            in_v = 3'b111;
            for (int i = 0; i < 3; i++) begin
                in_e[i] = mk_ent(rob_seq, 6'(c * 3 + i), 32'hA000_0000 + 32'(c * 3 + i));
                rob_seq = rob_seq + 6'd1;
            end
            step("saturate");
        end
        check_val("saturate_ovf_lit", 64'(cdb.overflow), 64'd1);

        // Asynchronous reset with buffered results: outputs clear at once, nothing replayed.
        idle_inputs();
        drive_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("midrst_bus0", 64'(cdb.bus0), 64'd0);
        check_val("midrst_bus1", 64'(cdb.bus1), 64'd0);
        check_val("midrst_ready", 64'(cdb.fu_ready), 64'h7);
        check_val("midrst_ovf", 64'(cdb.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step("post_reset_idle");

        // Randomized traffic, mostly honouring fu_ready.
        for (int c = 0; c < 300; c++) begin
            in_v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) in_v = in_v & model_ready();
            for (int i = 0; i < 3; i++) begin
                in_e[i] = mk_ent(rob_seq, 6'($urandom), $urandom);
                rob_seq = rob_seq + 6'd1;
            end
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
